// File: rtl/muldiv_seq_if.sv
// Request/response bundle for the sequential RV32M multiply/divide unit.
// slave = the unit, master = the issuing pipeline.
interface muldiv_seq_if #(parameter int TAG_WIDTH = 5);
  logic                 valid_i;
  logic                 ready_o;
  logic [2:0]           op_i;
  logic [31:0]          opa_i;
  logic [31:0]          opb_i;
  logic [TAG_WIDTH-1:0] tag_i;
  logic                 kill_i;
  logic                 valid_o;
  logic                 ready_i;
  logic [31:0]          result_o;
  logic [TAG_WIDTH-1:0] tag_o;
  logic                 illegal_o;
  logic                 busy_o;

  modport slave (
    input  valid_i, op_i, opa_i, opb_i, tag_i, kill_i, ready_i,
    output ready_o, valid_o, result_o, tag_o, illegal_o, busy_o
  );

  modport master (
    output valid_i, op_i, opa_i, opb_i, tag_i, kill_i, ready_i,
    input  ready_o, valid_o, result_o, tag_o, illegal_o, busy_o
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: 32-step shift-add / restoring divide on magnitudes.
// Division datapath is present only when MULDIV_SEQ_DIV_EN is defined.
module muldiv_seq #(
  parameter int TAG_WIDTH = 5
) (
  input logic         clk_i,
  input logic         rst_ni,
  muldiv_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e               state;
  logic [5:0]           cnt;
  logic [1:0]           op_q;
  logic                 neg_q;
  logic [31:0]          hi, lo, mc;
  logic                 valid_q, illegal_q;
  logic [31:0]          result_q;
  logic [TAG_WIDTH-1:0] tag_q;

  logic                 accept;
  logic                 a_sgn, b_sgn, neg_a, neg_b;
  logic [31:0]          mag_a, mag_b;
  logic [32:0]          add;
  logic [63:0]          prod, prod_s;

  assign accept = bus.valid_i && (state == IDLE) && !bus.kill_i;

  always_comb begin
    if (bus.op_i[2]) begin
      a_sgn = !bus.op_i[0];
      b_sgn = !bus.op_i[0];
    end else begin
      a_sgn = (bus.op_i[1:0] != 2'b11);
      b_sgn = !bus.op_i[1];
    end
    neg_a = a_sgn && bus.opa_i[31];
    neg_b = b_sgn && bus.opb_i[31];
    mag_a = neg_a ? (~bus.opa_i + 32'd1) : bus.opa_i;
    mag_b = neg_b ? (~bus.opb_i + 32'd1) : bus.opb_i;
  end

  // {hi,lo} doubles as the 64-bit product: hi accumulates, lo shifts out the multiplier
  assign add    = {1'b0, hi} + (lo[0] ? {1'b0, mc} : 33'd0);
  assign prod   = {hi, lo};
  assign prod_s = neg_q ? (~prod + 64'd1) : prod;

`ifdef MULDIV_SEQ_DIV_EN
  logic        neg_r;
  logic [33:0] diff;
  logic [31:0] quo_s, rem_s;
  logic        ovf;

  // restoring step: hi is the partial remainder, lo shifts dividend out / quotient in
  assign diff  = {1'b0, hi, lo[31]} - {2'b00, mc};
  assign quo_s = neg_q ? (~lo + 32'd1) : lo;
  assign rem_s = neg_r ? (~hi + 32'd1) : hi;
  assign ovf   = !bus.op_i[0] && (bus.opa_i == 32'h8000_0000) && (bus.opb_i == 32'hFFFF_FFFF);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
`ifdef MULDIV_SEQ_DIV_EN
      neg_r     <= 1'b0;
`endif
      hi        <= '0;
      lo        <= '0;
      mc        <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      result_q  <= '0;
      tag_q     <= '0;
    end else if (bus.kill_i && state != IDLE) begin
      state   <= IDLE;
      cnt     <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q      <= bus.op_i[1:0];
          tag_q     <= bus.tag_i;
          cnt       <= '0;
          illegal_q <= 1'b0;
          neg_q     <= neg_a ^ neg_b;
          hi        <= '0;
          if (!bus.op_i[2]) begin
            mc    <= mag_a;
            lo    <= mag_b;
            state <= MUL;
          end
`ifdef MULDIV_SEQ_DIV_EN
          else if (bus.opb_i == 32'd0) begin
            result_q <= bus.op_i[1] ? bus.opa_i : 32'hFFFF_FFFF;
            valid_q  <= 1'b1;
            state    <= DONE;
          end else if (ovf) begin
            result_q <= bus.op_i[1] ? 32'd0 : 32'h8000_0000;
            valid_q  <= 1'b1;
            state    <= DONE;
          end else begin
            neg_r <= neg_a;
            mc    <= mag_b;
            lo    <= mag_a;
            state <= DIV;
          end
`else
          else begin
            result_q  <= '0;
            illegal_q <= 1'b1;
            valid_q   <= 1'b1;
            state     <= DONE;
          end
`endif
        end
        MUL: begin
          if (cnt == 6'd32) begin
            result_q <= (op_q == 2'b00) ? prod_s[31:0] : prod_s[63:32];
            valid_q  <= 1'b1;
            state    <= DONE;
          end else begin
            hi  <= add[32:1];
            lo  <= {add[0], lo[31:1]};
            cnt <= cnt + 6'd1;
          end
        end
`ifdef MULDIV_SEQ_DIV_EN
        DIV: begin
          if (cnt == 6'd32) begin
            result_q <= op_q[1] ? rem_s : quo_s;
            valid_q  <= 1'b1;
            state    <= DONE;
          end else begin
            if (!diff[33]) begin
              hi <= diff[31:0];
              lo <= {lo[30:0], 1'b1};
            end else begin
              hi <= {hi[30:0], lo[31]};
              lo <= {lo[30:0], 1'b0};
            end
            cnt <= cnt + 6'd1;
          end
        end
`else
        DIV: state <= IDLE;
`endif
        DONE: if (bus.ready_i) begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready_o   = accept || ((state == IDLE) && !bus.kill_i && !bus.valid_i);
  assign bus.valid_o   = valid_q;
  assign bus.result_o  = result_q;
  assign bus.tag_o     = tag_q;
  assign bus.illegal_o = illegal_q;
  assign bus.busy_o    = (state != IDLE);

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized self-check of muldiv_seq against a plain-arithmetic RV32M model.
// Expectations follow MULDIV_SEQ_DIV_EN the same way the design build does.
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_seq_if #(.TAG_WIDTH(5)) bus();
  muldiv_seq #(.TAG_WIDTH(5)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // lat = edges after the accepting edge until valid_o is seen (bypass lands in DONE on that edge)
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill, output int lat);
    logic [63:0] sa, sb, ua, ub, p;
`ifdef MULDIV_SEQ_DIV_EN
    int ia, ib;
`endif
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ill = 1'b0;
    lat = 33;
    r   = '0;
    case (op)
      3'd0: begin p = sa * sb; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      default: begin
`ifdef MULDIV_SEQ_DIV_EN
        if (b == 32'd0) begin
          lat = 0;
          r   = op[1] ? a : 32'hFFFF_FFFF;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lat = 0;
          r   = op[1] ? 32'd0 : 32'h8000_0000;
        end else if (op[0]) begin
          r = op[1] ? (a % b) : (a / b);
        end else begin
          ia = a;
          ib = b;
          r  = op[1] ? (ia % ib) : (ia / ib);
        end
`else
        lat = 0;
        ill = 1'b1;
        r   = '0;
`endif
      end
    endcase
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input int stall);
    logic [31:0] er;
    logic        ei;
    int          el, n;
    model(op, a, b, er, ei, el);
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.op_i    = op;
    bus.opa_i   = a;
    bus.opb_i   = b;
    bus.tag_i   = tag;
    bus.ready_i = (stall == 0);
    chk("ready_idle", bus.ready_o, 1);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    bus.opa_i   = $urandom;
    bus.opb_i   = $urandom;
    bus.tag_i   = '0;
    n = 0;
    while (!bus.valid_o && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("latency op%0d", op), n, el);
    chk($sformatf("result op%0d %0h %0h", op, a, b), bus.result_o, er);
    chk("tag", bus.tag_o, tag);
    chk("illegal", bus.illegal_o, ei);
    chk("ready_done", bus.ready_o, 0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", bus.valid_o, 1);
      chk("hold_result", bus.result_o, er);
      chk("hold_tag", bus.tag_o, tag);
    end
    @(negedge clk);
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    chk("handoff_valid", bus.valid_o, 0);
    chk("handoff_ready", bus.ready_o, 1);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic        seen;
    bus.valid_i = 1'b0;
    bus.op_i    = '0;
    bus.opa_i   = '0;
    bus.opb_i   = '0;
    bus.tag_i   = '0;
    bus.kill_i  = 1'b0;
    bus.ready_i = 1'b1;

    #12;
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_result", bus.result_o, 0);
    chk("rst_tag", bus.tag_o, 0);
    chk("rst_illegal", bus.illegal_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_rst", bus.ready_o, 1);

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'h13, 5);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'h01, 0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h02, 0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h03, 0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'h04, 0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'h05, 0);
    do_op(3'd5, 32'd100, 32'd7, 5'h06, 0);
    do_op(3'd7, 32'd100, 32'd7, 5'h07, 2);
    do_op(3'd4, 32'd20, 32'd0, 5'h08, 0);
    do_op(3'd6, 32'd20, 32'd0, 5'h09, 0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'h0A, 0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'h0B, 0);
    do_op(3'd0, 32'd7, 32'd3, 5'h0C, 0);

    // kill ten iterations into a multiply
    @(negedge clk);
    bus.valid_i = 1'b1; bus.op_i = 3'd0; bus.opa_i = 32'd9; bus.opb_i = 32'd9; bus.tag_i = 5'h1F;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.kill_i = 1'b1;
    #1 chk("kill_ready_low", bus.ready_o, 0);
    @(posedge clk); #1;
    chk("kill_valid", bus.valid_o, 0);
    chk("kill_busy", bus.busy_o, 0);
    bus.kill_i = 1'b0;
    #1 chk("kill_ready_next", bus.ready_o, 1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.valid_o) seen = 1'b1;
    end
    chk("kill_no_valid", seen, 0);

    // kill while idle blocks acceptance
    @(negedge clk);
    bus.valid_i = 1'b1; bus.kill_i = 1'b1; bus.op_i = 3'd0;
    #1 chk("kill_idle_ready", bus.ready_o, 0);
    @(posedge clk); #1;
    chk("kill_idle_busy", bus.busy_o, 0);
    bus.valid_i = 1'b0; bus.kill_i = 1'b0;

    // reset asserted mid-divide, away from any clock edge
    @(negedge clk);
    bus.valid_i = 1'b1; bus.op_i = 3'd4; bus.opa_i = 32'd1000; bus.opb_i = 32'd3; bus.tag_i = 5'h1B;
    bus.ready_i = 1'b0;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", bus.valid_o, 0);
    chk("midrst_busy", bus.busy_o, 0);
    chk("midrst_result", bus.result_o, 0);
    chk("midrst_tag", bus.tag_o, 0);
    chk("midrst_illegal", bus.illegal_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.ready_i = 1'b1;
    #1 chk("midrst_ready", bus.ready_o, 1);

    for (int k = 0; k < 40; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin rb = 32'hFFFF_FFFF; ra = 32'h8000_0000; end
        2: rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      do_op(rop, ra, rb, 5'($urandom), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 5, width of destination-register tag carried with each operation.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port valid_i  input  1  operation request valid.
REQ-005 SHALL have port ready_o  output  1  unit can accept an operation this cycle.
REQ-006 SHALL have port op_i  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port opa_i  input  32  rs1 operand.
REQ-008 SHALL have port opb_i  input  32  rs2 operand.
REQ-009 SHALL have port tag_i  input  TAG_WIDTH  destination register tag.
REQ-010 SHALL have port kill_i  input  1  abort in-flight or pending operation (pipeline flush).
REQ-011 SHALL have port valid_o  output  1  result valid.
REQ-012 SHALL have port ready_i  input  1  consumer accepts result.
REQ-013 SHALL have port result_o  output  32  result word.
REQ-014 SHALL have port tag_o  output  TAG_WIDTH  tag captured at acceptance.
REQ-015 SHALL have port illegal_o  output  1  operation unsupported in this build; qualified by valid_o.
REQ-016 SHALL have port busy_o  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-018 SHALL drive ready_o = (state==IDLE) && !kill_i; an operation is accepted on a cycle with valid_i && ready_o, latching op_i, opa_i, opb_i, tag_i.
REQ-019 SHALL, on accepting an op 0xx, enter MUL and iterate radix-2 shift-add on operand magnitudes for exactly 32 cycles, then enter DONE; signs per op (MULHSU: opa signed, opb unsigned).
REQ-020 SHALL, on accepting an op 1xx, enter DIV and iterate restoring division on magnitudes for exactly 32 cycles, then enter DONE; quotient sign = sign(a) XOR sign(b), remainder sign = sign(a) for signed ops.
REQ-021 SHALL give latency 33 cycles: acceptance at edge N, valid_o high in the cycle after edge N+33.
REQ-022 SHALL bypass iteration for divide-by-zero (quotient 0xFFFFFFFF, remainder = opa) and signed overflow 0x80000000 / 0xFFFFFFFF (quotient 0x80000000, remainder 0): go directly IDLE->DONE, latency 1 cycle.
REQ-023 SHALL select result_o: MUL low 32 bits; MULH/MULHSU/MULHU high 32 bits of 64-bit product; DIV/DIVU quotient; REM/REMU remainder.
REQ-024 SHALL hold valid_o, result_o, tag_o, illegal_o stable in DONE until ready_i is high, then return to IDLE on that edge.
REQ-025 SHALL not accept a new operation in the cycle a result is handed off (ready_o is low in DONE).
REQ-026 SHALL, when kill_i is high in MUL, DIV or DONE, return to IDLE on the next edge with valid_o low from that cycle; kill_i in IDLE suppresses acceptance.
REQ-027 SHALL drive valid_o only in DONE; result_o and tag_o are don't-care while valid_o is low.

Reset
REQ-028 SHALL, while rst_ni is low, force state IDLE, iteration counter 0, valid_o 0, busy_o 0, illegal_o 0, result_o 0, tag_o 0, regardless of clk_i.
REQ-029 SHALL discard any in-flight operation on reset assertion; ready_o is 1 in the first cycle after rst_ni deasserts (kill_i low).

Configuration
REQ-030 SHALL, with macro MULDIV_SEQ_DIV_EN defined, implement DIV, DIVU, REM, REMU per REQ-020/022 and tie illegal_o to 0.
REQ-031 SHALL, without MULDIV_SEQ_DIV_EN, omit division datapath; ops 1xx go IDLE->DONE in 1 cycle with result_o 0 and illegal_o 1; MUL ops unchanged.

Verification
REQ-032 SHALL cover: MUL 7 x 0xFFFFFFFD (-3) -> result_o 0xFFFFFFEB, valid_o exactly 33 cycles after acceptance, tag_o = tag_i.
REQ-033 SHALL cover: MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-034 SHALL cover: DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF, 33-cycle latency; DIVU 100 / 7 -> 14, REMU -> 2.
REQ-035 SHALL cover: DIV 20 / 0 -> 0xFFFFFFFF, REM 20 / 0 -> 20, DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0, each with valid_o 1 cycle after acceptance.
REQ-036 SHALL cover: ready_i low 5 cycles in DONE -> outputs held stable; kill_i at iteration 10 -> valid_o never asserts, ready_o high next cycle; rst_ni low mid-DIV -> all outputs 0 immediately.
REQ-037 SHALL cover: build without MULDIV_SEQ_DIV_EN, DIVU 100 / 7 -> valid_o after 1 cycle, illegal_o 1, result_o 0; MUL 7 x 3 -> 21, illegal_o 0.
